riscv_fetch_pc: RTL

//  Program-counter and instruction-fetch sequencer for the RV32I multi-cycle core.

---
 rtl/riscv_fetch_pc.sv | 77 +++++++
 1 files changed

// File: rtl/riscv_fetch_pc.sv
// riscv_fetch_pc: PC register and single-outstanding IMEM fetch sequencer for the multi-cycle RV32I core.
module riscv_fetch_pc #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter bit              CHK_ALIGN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    input  logic            i_instr_ready,
    input  logic            i_exec_done,
    input  logic [1:0]      i_src_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    output logic            o_misaligned
);
    localparam logic [1:0] SRC_PC_PC_IMM = 2'd1;
    localparam logic [1:0] SRC_PC_RS_IMM = 2'd2;
    typedef enum logic [2:0] {S_REQ, S_RSP, S_ISSUE, S_EXEC, S_TRAP} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, next_pc;
    logic [31:0]     instr_q, instr_d;
    always_comb begin
        next_pc = (i_src_pc == SRC_PC_PC_IMM) ? pc_q + i_imm :
                  (i_src_pc == SRC_PC_RS_IMM) ? (i_rs1 + i_imm) & ~XLEN'(1) :
                                                pc_q + XLEN'(4);
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_REQ:   state_d = i_imem_req_ready ? S_RSP : S_REQ;
            S_RSP: begin
                if (i_imem_rsp_valid) begin
                    instr_d = i_imem_rsp_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = i_instr_ready ? S_EXEC : S_ISSUE;
            S_EXEC: begin
                if (i_exec_done) begin
                    pc_d    = next_pc;
                    state_d = (CHK_ALIGN && next_pc[1:0] != 2'b00) ? S_TRAP : S_REQ;
                end
            end
            default: state_d = S_TRAP;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end
    // The request is masked while reset is held so every valid reads low during reset.
    assign o_imem_req_valid = (state_q == S_REQ) && !i_rst;
    assign o_imem_addr      = pc_q;
    assign o_instr_valid    = state_q == S_ISSUE;
    assign o_instr          = instr_q;
    assign o_pc             = pc_q;
    assign o_pc_plus4       = pc_q + XLEN'(4);
    assign o_misaligned     = state_q == S_TRAP;
endmodule
